playlist_sequencer: RTL and testbench
=====================================

// Module: playlist_sequencer
// PURPOSE
//  Command-side controller for the score reader. Arbitrates keypad commands against
//  automatic end-of-song advance and issues one-cycle 5-bit commands on the score
//  reader's keybord input: 10000 play, 10001 pause, 10010 stop, 101ss select song ss.
//  Supports four play modes and an inter-song silence gap. Sits between keypad decoder and score reader.
// PARAMETERS
//  SETTLE_CYC  4           cycles between song-select cmd and play cmd (score ROM re-addressing)
//  ARM_CYC     16          max cycles to wait for playing_i=1 after play cmd; then song is treated as empty
//  GAP_CYC     12_000_000  silence cycles between auto-advanced songs (24-bit counter)
//  LFSR_SEED   8'hA5       shuffle LFSR reset value; must be non-zero
// PORTS
//  clk        in   1  system clock, single domain
//  reset      in   1  asynchronous, active-high reset
//  key_valid  in   1  one-cycle strobe; key_code is valid
//  key_code   in   5  10000 play/pause toggle, 10010 stop, 11000 next, 11001 prev, 101ss direct select
//  mode       in   2  00 single, 01 repeat-one, 10 repeat-all, 11 shuffle; sampled only when choosing the next song
//  playing_i  in   1  score reader playing flag
//  cmd        out  5  command to score reader; 00000 when idle; any other value is held for exactly 1 cycle
//  song_idx   out  2  currently selected song
//  state_o    out  3  FSM state encoding (debug)
//  busy       out  1  1 in every state except IDLE
// BEHAVIOUR
//  Reset: cmd=00000, song_idx=01, state=IDLE, busy=0, LFSR=LFSR_SEED, all counters 0.
//  Reset mid-operation aborts immediately; no stop cmd is issued.
//  States: IDLE, SEL, SETTLE, GO, ARM, PLAY, PAUSED, GAP.
//   IDLE:   play key -> SEL with current song_idx; select key ss -> song_idx=ss, SEL.
//           Other keys are ignored.
//   SEL:    cmd=101{song_idx} for 1 cycle -> SETTLE.
//   SETTLE: count SETTLE_CYC cycles -> GO.
//   GO:     cmd=10000 for 1 cycle -> ARM.
//   ARM:    playing_i=1 -> PLAY. ARM_CYC elapses first -> treat as end-of-song (ADV).
//   PLAY:   play key -> cmd=10001, PAUSED. stop key -> cmd=10010, IDLE.
//           next/prev/select key -> update song_idx, SEL (no gap).
//           playing_i falls with no key this cycle -> end-of-song (ADV).
//   PAUSED: play key -> GO. stop -> cmd=10010, IDLE. next/prev/select -> SEL.
//           playing_i is ignored in this state.
//   GAP:    count GAP_CYC cycles -> SEL. Any key aborts the gap and is handled as in PLAY;
//           play key in GAP -> SEL immediately.
//  ADV (end-of-song decision, taken in the same cycle):
//   mode 00 -> IDLE; song_idx unchanged.
//   mode 01 -> GAP; same song.
//   mode 10 -> GAP; song_idx+1 mod 4.
//   mode 11 -> GAP; song_idx=lfsr[1:0], or lfsr[1:0]+1 mod 4 if that equals the current song.
//  next = +1 mod 4 (3 -> 0). prev = -1 mod 4 (0 -> 3).
//  LFSR: 8-bit Fibonacci, taps 8,6,5,4; advances every clk regardless of state.
//  Priority within one cycle: reset > key_valid > playing_i edge > counter expiry.
//  A key that coincides with end-of-song wins; the end-of-song event is dropped.
//  playing_i fall detection uses a registered copy of playing_i. The copy is cleared
//   on every SEL so that a stale fall is never seen.
//  cmd is registered: it appears the cycle after the state transition that issues it.
//   Only one cmd is issued per transition.
//  Counters saturate/clear on state entry; the GAP counter is 24 bits, compare is >= GAP_CYC-1.
// STRUCTURE
//  Shared package: key/cmd code constants (CMD_IDLE, CMD_PLAY, CMD_PAUSE, CMD_STOP,
//   CMD_SEL_BASE, KEY_NEXT, KEY_PREV), mode constants, state encoding.
//  One sub-module: shuffle_lfsr (8-bit, seed param, outputs q[7:0]).
//  The FSM, counters and the next-song function stay in playlist_sequencer.
// TESTING (GAP_CYC=32 in sim)
//  1. Reset, key 10000 -> cmd 10101 @+2, then cmd 10000 after 4 settle cycles; song_idx=1, busy=1.
//  2. mode=10, song 3 playing, playing_i 1->0 -> GAP 32 cycles, then cmd 10100; song_idx wraps to 0.
//  3. PLAY, key 10000 -> cmd 10001, PAUSED; playing_i drop ignored; key 10000 -> cmd 10000, no select.
//  4. Same cycle: key 11001 (prev) and playing_i fall at song 0 -> song_idx=3, SEL, no GAP entered.
//  5. mode=11, 200 end-of-song events -> never the same song twice in a row; all 4 songs hit.
//  6. After GO, playing_i held 0 for 16 cycles with mode=00 -> IDLE, cmd 00000; reset mid-GAP -> IDLE next cycle.

Source files
------------

// File: rtl/playlist_sequencer_pkg.sv
// playlist_sequencer_pkg: shared command/key codes, play modes and FSM state encoding
package playlist_sequencer_pkg;
    localparam logic [4:0] CMD_IDLE     = 5'b00000;
    localparam logic [4:0] CMD_PLAY     = 5'b10000;
    localparam logic [4:0] CMD_PAUSE    = 5'b10001;
    localparam logic [4:0] CMD_STOP     = 5'b10010;
    localparam logic [4:0] CMD_SEL_BASE = 5'b10100;
    localparam logic [4:0] KEY_NEXT     = 5'b11000;
    localparam logic [4:0] KEY_PREV     = 5'b11001;

    localparam logic [1:0] MODE_SINGLE     = 2'b00;
    localparam logic [1:0] MODE_REPEAT_ONE = 2'b01;
    localparam logic [1:0] MODE_REPEAT_ALL = 2'b10;
    localparam logic [1:0] MODE_SHUFFLE    = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE, S_SEL, S_SETTLE, S_GO, S_ARM, S_PLAY, S_PAUSED, S_GAP
    } state_t;

    function automatic logic [4:0] sel_cmd(input logic [1:0] s);
        return CMD_SEL_BASE | {3'b000, s};
    endfunction
endpackage

// File: rtl/playlist_sequencer_shuffle_lfsr.sv
// shuffle_lfsr: free-running 8-bit Fibonacci LFSR (taps 8,6,5,4) used to pick shuffle songs
//  clk   in  system clock
//  reset in  asynchronous active-high reset, loads SEED
//  q     out current LFSR state
module shuffle_lfsr #(
    parameter logic [7:0] SEED = 8'hA5
) (
    input  logic       clk,
    input  logic       reset,
    output logic [7:0] q
);
    always_ff @(posedge clk or posedge reset)
        if (reset) q <= SEED;
        else       q <= {q[6:0], q[7] ^ q[5] ^ q[4] ^ q[3]};
endmodule

// File: rtl/playlist_sequencer.sv
// playlist_sequencer: arbitrates keypad commands and end-of-song advance into score reader commands
//  clk        in  system clock
//  reset      in  asynchronous active-high reset
//  key_valid  in  one-cycle strobe qualifying key_code
//  key_code   in  10000 play/pause, 10010 stop, 11000 next, 11001 prev, 101ss select
//  mode       in  00 single, 01 repeat-one, 10 repeat-all, 11 shuffle
//  playing_i  in  score reader playing flag
//  cmd        out one-cycle command to the score reader, 00000 when idle
//  song_idx   out currently selected song
//  state_o    out FSM state (debug)
//  busy       out high in every state except IDLE
module playlist_sequencer
    import playlist_sequencer_pkg::*;
#(
    parameter int         SETTLE_CYC = 4,
    parameter int         ARM_CYC    = 16,
    parameter int         GAP_CYC    = 12_000_000,
    parameter logic [7:0] LFSR_SEED  = 8'hA5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       key_valid,
    input  logic [4:0] key_code,
    input  logic [1:0] mode,
    input  logic       playing_i,
    output logic [4:0] cmd,
    output logic [1:0] song_idx,
    output logic [2:0] state_o,
    output logic       busy
);
    localparam logic [23:0] SETTLE_LAST = 24'(SETTLE_CYC - 1);
    localparam logic [23:0] ARM_LAST    = 24'(ARM_CYC - 1);
    localparam logic [23:0] GAP_LAST    = 24'(GAP_CYC - 1);

    state_t      state, nstate, adv_state;
    logic [1:0]  song, nsong, adv_song, nav_song, rnd, shuf;
    logic [4:0]  ncmd;
    logic [23:0] cnt;
    logic        prev_play, fall;
    logic        is_play, is_stop, is_next, is_prev, is_sel, nav;
    logic [5:0]  unused_lfsr;

    shuffle_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
        .clk   (clk),
        .reset (reset),
        .q     ({unused_lfsr, rnd})
    );

    assign is_play  = key_valid && key_code == CMD_PLAY;
    assign is_stop  = key_valid && key_code == CMD_STOP;
    assign is_next  = key_valid && key_code == KEY_NEXT;
    assign is_prev  = key_valid && key_code == KEY_PREV;
    assign is_sel   = key_valid && key_code[4:2] == CMD_SEL_BASE[4:2];
    assign nav      = is_next || is_prev || is_sel;
    assign nav_song = is_next ? song + 2'd1 : is_prev ? song - 2'd1 : key_code[1:0];
    assign fall     = prev_play && !playing_i;

    // Shuffle never repeats the current song: a collision bumps to the next one.
    assign shuf      = (rnd == song) ? rnd + 2'd1 : rnd;
    assign adv_song  = (mode == MODE_REPEAT_ALL) ? song + 2'd1 : (mode == MODE_SHUFFLE) ? shuf : song;
    assign adv_state = (mode == MODE_SINGLE) ? S_IDLE : S_GAP;

    always_comb begin
        nstate = state;
        nsong  = song;
        ncmd   = CMD_IDLE;
        case (state)
            S_IDLE:
                if (is_play) nstate = S_SEL;
                else if (is_sel) begin
                    nsong  = key_code[1:0];
                    nstate = S_SEL;
                end
            S_SEL: begin
                ncmd   = sel_cmd(song);
                nstate = S_SETTLE;
            end
            S_SETTLE: if (cnt >= SETTLE_LAST) nstate = S_GO;
            S_GO: begin
                ncmd   = CMD_PLAY;
                nstate = S_ARM;
            end
            S_ARM:
                if (playing_i) nstate = S_PLAY;
                else if (cnt >= ARM_LAST) begin
                    nstate = adv_state;
                    nsong  = adv_song;
                end
            default: // PLAY, PAUSED, GAP share key handling; keys beat end-of-song and gap expiry
                if (is_stop) begin
                    ncmd   = CMD_STOP;
                    nstate = S_IDLE;
                end else if (nav) begin
                    nsong  = nav_song;
                    nstate = S_SEL;
                end else if (is_play) begin
                    nstate = (state == S_PLAY) ? S_PAUSED : (state == S_PAUSED) ? S_GO : S_SEL;
                    ncmd   = (state == S_PLAY) ? CMD_PAUSE : CMD_IDLE;
                end else if (state == S_PLAY && fall) begin
                    nstate = adv_state;
                    nsong  = adv_song;
                end else if (state == S_GAP && cnt >= GAP_LAST) nstate = S_SEL;
        endcase
    end

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            state     <= S_IDLE;
            song      <= 2'd1;
            cmd       <= CMD_IDLE;
            cnt       <= '0;
            prev_play <= 1'b0;
        end else begin
            state     <= nstate;
            song      <= nsong;
            cmd       <= ncmd;
            cnt       <= (nstate != state) ? '0 : (&cnt ? cnt : cnt + 24'd1);
            // Cleared in SEL so a fall left over from the previous song is never seen.
            prev_play <= (state == S_SEL) ? 1'b0 : playing_i;
        end

    assign song_idx = song;
    assign state_o  = state;
    assign busy     = state != S_IDLE;
endmodule

// File: tb/tb_playlist_sequencer.sv
// tb_playlist_sequencer: scoreboard bench for playlist_sequencer
module tb_playlist_sequencer;
    import playlist_sequencer_pkg::*;

    logic       clk, reset, key_valid, playing_i;
    logic [4:0] key_code, cmd;
    logic [1:0] mode, song_idx;
    logic [2:0] state_o;
    logic       busy;
    logic [7:0] m_lfsr;
    logic [4:0] expq[$];
    logic [4:0] exp_cmd;
    int         errors = 0;
    int         checks = 0;

    playlist_sequencer #(.SETTLE_CYC(4), .ARM_CYC(16), .GAP_CYC(32), .LFSR_SEED(8'hA5)) dut (
        .clk(clk), .reset(reset), .key_valid(key_valid), .key_code(key_code), .mode(mode),
        .playing_i(playing_i), .cmd(cmd), .song_idx(song_idx), .state_o(state_o), .busy(busy)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk or posedge reset)
        if (reset) m_lfsr <= 8'hA5;
        else       m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};

    always @(negedge clk)
        if (!reset && cmd !== CMD_IDLE) begin
            checks++;
            if (expq.size() == 0) begin
                errors++;
                $display("FAIL cmd_unexpected: got %b, expected no command", cmd);
            end else begin
                exp_cmd = expq.pop_front();
                if (cmd !== exp_cmd) begin
                    errors++;
                    $display("FAIL cmd_scoreboard: got %b, expected %b", cmd, exp_cmd);
                end
            end
        end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1; key_valid = 0; key_code = 0; playing_i = 0; mode = MODE_SINGLE;
        expq.delete();
        repeat (2) tick();
        reset = 0;
    endtask

    task automatic press(input logic [4:0] code);
        key_valid = 1; key_code = code;
        tick();
        key_valid = 0;
    endtask

    task automatic wait_state(input logic [2:0] s, input int budget, input string name);
        int n = 0;
        while (state_o !== s && n < budget) begin tick(); n++; end
        checks++;
        if (state_o !== s) begin errors++; $display("FAIL %s: state %0d, expected %0d within %0d cycles", name, state_o, s, budget); end
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (cmd !== 5'b00000) begin errors++; $display("FAIL rst_cmd: got %b expected 00000", cmd); end
        checks++; if (song_idx !== 2'd1) begin errors++; $display("FAIL rst_song: got %0d expected 1", song_idx); end
        checks++; if (state_o !== S_IDLE) begin errors++; $display("FAIL rst_state: got %0d expected %0d", state_o, S_IDLE); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b expected 0", busy); end
        press(KEY_NEXT);
        checks++; if (state_o !== S_IDLE || song_idx !== 2'd1) begin errors++; $display("FAIL idle_ignore_next: state %0d song %0d expected 0/1", state_o, song_idx); end
    endtask

    task automatic test_start();
        expq.push_back(5'b10101);
        expq.push_back(CMD_PLAY);
        press(CMD_PLAY);
        checks++; if (state_o !== S_SEL || cmd !== 5'b0) begin errors++; $display("FAIL start_sel: state %0d cmd %b expected %0d/00000", state_o, cmd, S_SEL); end
        tick();
        checks++; if (cmd !== 5'b10101) begin errors++; $display("FAIL start_sel_cmd: got %b expected 10101", cmd); end
        repeat (4) tick();
        checks++; if (state_o !== S_GO || cmd !== 5'b0) begin errors++; $display("FAIL start_go: state %0d cmd %b expected %0d/00000", state_o, cmd, S_GO); end
        tick();
        checks++; if (cmd !== CMD_PLAY) begin errors++; $display("FAIL start_play_cmd: got %b expected 10000", cmd); end
        checks++; if (song_idx !== 2'd1 || busy !== 1'b1) begin errors++; $display("FAIL start_song_busy: song %0d busy %b expected 1/1", song_idx, busy); end
        playing_i = 1;
        tick();
        checks++; if (state_o !== S_PLAY) begin errors++; $display("FAIL start_play_state: got %0d expected %0d", state_o, S_PLAY); end
    endtask

    task automatic test_pause();
        expq.push_back(CMD_PAUSE);
        press(CMD_PLAY);
        checks++; if (state_o !== S_PAUSED || cmd !== CMD_PAUSE) begin errors++; $display("FAIL pause: state %0d cmd %b expected %0d/10001", state_o, cmd, S_PAUSED); end
        playing_i = 0;
        repeat (3) tick();
        checks++; if (state_o !== S_PAUSED) begin errors++; $display("FAIL pause_ignore_fall: state %0d expected %0d", state_o, S_PAUSED); end
        expq.push_back(CMD_PLAY);
        press(CMD_PLAY);
        checks++; if (state_o !== S_GO) begin errors++; $display("FAIL resume_go: state %0d expected %0d", state_o, S_GO); end
        playing_i = 1;
        tick();
        checks++; if (cmd !== CMD_PLAY || state_o !== S_ARM) begin errors++; $display("FAIL resume_cmd: cmd %b state %0d expected 10000/%0d", cmd, state_o, S_ARM); end
        tick();
        checks++; if (state_o !== S_PLAY) begin errors++; $display("FAIL resume_play: state %0d expected %0d", state_o, S_PLAY); end
    endtask

    task automatic test_wrap_gap();
        do_reset();
        mode = MODE_REPEAT_ALL; playing_i = 1;
        expq.push_back(5'b10111);
        expq.push_back(CMD_PLAY);
        press(5'b10111);
        wait_state(S_PLAY, 20, "wrap_reach_play");
        checks++; if (song_idx !== 2'd3) begin errors++; $display("FAIL wrap_song3: got %0d expected 3", song_idx); end
        playing_i = 0;
        expq.push_back(5'b10100);
        expq.push_back(CMD_PLAY);
        tick();
        checks++; if (state_o !== S_GAP || song_idx !== 2'd0) begin errors++; $display("FAIL wrap_gap: state %0d song %0d expected %0d/0", state_o, song_idx, S_GAP); end
        repeat (31) tick();
        checks++; if (state_o !== S_GAP) begin errors++; $display("FAIL gap_len_min: state %0d expected %0d", state_o, S_GAP); end
        tick();
        checks++; if (state_o !== S_SEL) begin errors++; $display("FAIL gap_len_end: state %0d expected %0d", state_o, S_SEL); end
        tick();
        checks++; if (cmd !== 5'b10100) begin errors++; $display("FAIL wrap_sel_cmd: got %b expected 10100", cmd); end
    endtask

    task automatic test_key_wins();
        do_reset();
        mode = MODE_REPEAT_ALL; playing_i = 1;
        expq.push_back(5'b10100);
        expq.push_back(CMD_PLAY);
        press(5'b10100);
        wait_state(S_PLAY, 20, "kw_reach_play");
        playing_i = 0;
        expq.push_back(5'b10111);
        expq.push_back(CMD_PLAY);
        press(KEY_PREV);
        checks++; if (state_o !== S_SEL || song_idx !== 2'd3) begin errors++; $display("FAIL kw_prev: state %0d song %0d expected %0d/3", state_o, song_idx, S_SEL); end
        tick();
        checks++; if (state_o !== S_SETTLE) begin errors++; $display("FAIL kw_no_gap: state %0d expected %0d", state_o, S_SETTLE); end
    endtask

    task automatic test_shuffle();
        logic [1:0] cur, exp_song;
        logic [3:0] hits = 4'b0;
        do_reset();
        mode = MODE_SHUFFLE; playing_i = 1;
        expq.push_back(5'b10101);
        expq.push_back(CMD_PLAY);
        press(CMD_PLAY);
        for (int i = 0; i < 200; i++) begin
            wait_state(S_PLAY, 80, "shuf_reach_play");
            cur = song_idx;
            exp_song = (m_lfsr[1:0] == cur) ? m_lfsr[1:0] + 2'd1 : m_lfsr[1:0];
            playing_i = 0;
            expq.push_back(CMD_SEL_BASE | {3'b0, exp_song});
            expq.push_back(CMD_PLAY);
            tick();
            playing_i = 1;
            checks++; if (state_o !== S_GAP) begin errors++; $display("FAIL shuf_gap[%0d]: state %0d expected %0d", i, state_o, S_GAP); end
            checks++; if (song_idx !== exp_song) begin errors++; $display("FAIL shuf_song[%0d]: got %0d expected %0d", i, song_idx, exp_song); end
            checks++; if (song_idx === cur) begin errors++; $display("FAIL shuf_repeat[%0d]: got %0d, expected anything but %0d", i, song_idx, cur); end
            hits[song_idx] = 1'b1;
        end
        checks++; if (hits !== 4'b1111) begin errors++; $display("FAIL shuf_coverage: songs hit %b expected 1111", hits); end
    endtask

    task automatic test_arm_timeout();
        do_reset();
        expq.push_back(5'b10101);
        expq.push_back(CMD_PLAY);
        press(CMD_PLAY);
        repeat (6) tick();
        checks++; if (state_o !== S_ARM || cmd !== CMD_PLAY) begin errors++; $display("FAIL arm_entry: state %0d cmd %b expected %0d/10000", state_o, cmd, S_ARM); end
        repeat (15) tick();
        checks++; if (state_o !== S_ARM) begin errors++; $display("FAIL arm_hold: state %0d expected %0d", state_o, S_ARM); end
        tick();
        checks++; if (state_o !== S_IDLE || cmd !== 5'b0 || busy !== 1'b0 || song_idx !== 2'd1) begin errors++; $display("FAIL arm_timeout: state %0d cmd %b busy %b song %0d expected 0/00000/0/1", state_o, cmd, busy, song_idx); end
    endtask

    task automatic test_reset_mid_gap();
        mode = MODE_REPEAT_ONE; playing_i = 1;
        expq.push_back(5'b10101);
        expq.push_back(CMD_PLAY);
        press(CMD_PLAY);
        wait_state(S_PLAY, 20, "rg_reach_play");
        playing_i = 0;
        tick();
        checks++; if (state_o !== S_GAP || song_idx !== 2'd1) begin errors++; $display("FAIL rg_gap: state %0d song %0d expected %0d/1", state_o, song_idx, S_GAP); end
        repeat (5) tick();
        reset = 1;
        #1;
        checks++; if (state_o !== S_IDLE || busy !== 1'b0 || cmd !== 5'b0) begin errors++; $display("FAIL rg_abort: state %0d busy %b cmd %b expected 0/0/00000", state_o, busy, cmd); end
        expq.delete();
        tick();
        reset = 0;
        repeat (40) tick();
        checks++; if (state_o !== S_IDLE || cmd !== 5'b0) begin errors++; $display("FAIL rg_stay_idle: state %0d cmd %b expected 0/00000", state_o, cmd); end
    endtask

    initial begin
        test_reset();
        test_start();
        test_pause();
        test_wrap_gap();
        test_key_wins();
        test_shuffle();
        test_arm_timeout();
        test_reset_mid_gap();
        checks++; if (expq.size() != 0) begin errors++; $display("FAIL cmd_leftover: %0d commands never issued, expected 0", expq.size()); end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
